// File: rtl/qspi_rom_responder.sv
// qspi_rom_responder: QSPI Fast Read Quad I/O (0xEB) target that serves bytes from a
// synchronous ROM port. SPI pins are oversampled on clk; SCK is never used as a clock.
module qspi_rom_responder #(
  parameter int ADDR_BITS   = 24,
  parameter int MEM_BITS    = 12,
  parameter int DUMMY_CLKS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                spi_select,
  input  logic                spi_clk,
  input  logic [3:0]          spi_data_in,
  output logic [3:0]          spi_data_out,
  output logic [3:0]          spi_data_oe,
  output logic [MEM_BITS-1:0] mem_addr,
  output logic                mem_rd,
  input  logic [7:0]          mem_data,
  output logic                busy,
  output logic                cmd_error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    ADDR   = 3'd2,
    MODE   = 3'd3,
    DUMMY  = 3'd4,
    DATA   = 3'd5,
    IGNORE = 3'd6
  } state_t;

  localparam logic [7:0] CMD_LAST   = 8'd7;
  localparam logic [7:0] ADDR_LAST  = 8'(ADDR_BITS / 4 - 1);
  localparam logic [7:0] MODE_LAST  = 8'd1;
  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_CLKS - 1);
  localparam logic [7:0] READ_CMD   = 8'hEB;

  logic [SYNC_STAGES-1:0]      cs_sync_r;
  logic [SYNC_STAGES-1:0]      sck_sync_r;
  logic [SYNC_STAGES-1:0][3:0] sd_sync_r;
  logic                        sck_prev_r;
  logic                        cs_s;
  logic                        sck_s;
  logic [3:0]                  sd_s;
  logic                        rise_s;
  logic                        fall_s;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [7:0]                  cnt_r;
  logic [6:0]                  cmd_r;
  logic [ADDR_BITS-1:0]        addr_r;
  logic [ADDR_BITS-1:0]        addr_inc_s;
  logic [7:0]                  byte_r;
  logic [7:0]                  prefetch_r;
  logic                        nib_lo_r;
  logic                        first_r;
  logic                        rd_dly_r;

  logic [3:0]                  out_r;
  logic [3:0]                  oe_r;
  logic [MEM_BITS-1:0]         mem_addr_r;
  logic                        mem_rd_r;
  logic                        busy_r;
  logic                        cmd_error_r;
  logic [3:0]                  out_nxt_s;
  logic [3:0]                  oe_nxt_s;
  logic                        rd_nxt_s;
  logic [MEM_BITS-1:0]         maddr_nxt_s;

  // CS resets to its idle (high) level so a reset never looks like a select
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_r  <= {SYNC_STAGES{1'b1}};
      sck_sync_r <= {SYNC_STAGES{1'b0}};
      sd_sync_r  <= {(SYNC_STAGES * 4){1'b0}};
      sck_prev_r <= 1'b0;
    end else begin
      cs_sync_r  <= {cs_sync_r[SYNC_STAGES-2:0], spi_select};
      sck_sync_r <= {sck_sync_r[SYNC_STAGES-2:0], spi_clk};
      sd_sync_r  <= {sd_sync_r[SYNC_STAGES-2:0], spi_data_in};
      sck_prev_r <= sck_s;
    end
  end

  assign cs_s       = cs_sync_r[SYNC_STAGES-1];
  assign sck_s      = sck_sync_r[SYNC_STAGES-1];
  assign sd_s       = sd_sync_r[SYNC_STAGES-1];
  // A deselect in the same clk as an SCK edge wins: the edge is dropped
  assign rise_s     = sck_s & ~sck_prev_r & ~cs_s;
  assign fall_s     = ~sck_s & sck_prev_r & ~cs_s;
  assign addr_inc_s = addr_r + ADDR_BITS'(1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode, one step per synchronised SCK rise
  always_comb begin
    state_nxt_s = state_r;
    if (cs_s) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = CMD;
        CMD: begin
          if (rise_s && cnt_r == CMD_LAST) begin
            state_nxt_s = ({cmd_r, sd_s[0]} == READ_CMD) ? ADDR : IGNORE;
          end else begin
            state_nxt_s = CMD;
          end
        end
        ADDR: begin
          if (rise_s && cnt_r == ADDR_LAST) begin
            state_nxt_s = MODE;
          end else begin
            state_nxt_s = ADDR;
          end
        end
        MODE: begin
          if (rise_s && cnt_r == MODE_LAST) begin
            state_nxt_s = DUMMY;
          end else begin
            state_nxt_s = MODE;
          end
        end
        DUMMY: begin
          if (rise_s && cnt_r == DUMMY_LAST) begin
            state_nxt_s = DATA;
          end else begin
            state_nxt_s = DUMMY;
          end
        end
        DATA:    state_nxt_s = DATA;
        IGNORE:  state_nxt_s = IGNORE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Next values of the pin drivers and the ROM read request
  always_comb begin
    oe_nxt_s    = 4'h0;
    out_nxt_s   = 4'h0;
    rd_nxt_s    = 1'b0;
    maddr_nxt_s = mem_addr_r;
    if (state_nxt_s == DATA) begin
      oe_nxt_s = 4'hF;
      if (state_r == DATA && fall_s && !nib_lo_r) begin
        out_nxt_s = first_r ? byte_r[7:4] : prefetch_r[7:4];
      end else if (state_r == DATA && fall_s) begin
        out_nxt_s   = byte_r[3:0];
        rd_nxt_s    = 1'b1;
        maddr_nxt_s = addr_inc_s[MEM_BITS-1:0];
      end else begin
        out_nxt_s = out_r;
      end
    end else if (state_nxt_s == DUMMY && state_r != DUMMY) begin
      rd_nxt_s    = 1'b1;
      maddr_nxt_s = addr_r[MEM_BITS-1:0];
    end else begin
      rd_nxt_s = 1'b0;
    end
  end

  // Registered outputs; cmd_error only ever sets outside of reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_r       <= 4'h0;
      oe_r        <= 4'h0;
      mem_addr_r  <= {MEM_BITS{1'b0}};
      mem_rd_r    <= 1'b0;
      busy_r      <= 1'b0;
      cmd_error_r <= 1'b0;
    end else begin
      out_r       <= out_nxt_s;
      oe_r        <= oe_nxt_s;
      mem_addr_r  <= maddr_nxt_s;
      mem_rd_r    <= rd_nxt_s;
      busy_r      <= (state_nxt_s != IDLE);
      cmd_error_r <= cmd_error_r | (state_r == CMD && state_nxt_s == IGNORE);
    end
  end

  // Shift registers, phase counter, nibble tracking and the byte/prefetch pair
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= 8'd0;
      cmd_r      <= 7'd0;
      addr_r     <= {ADDR_BITS{1'b0}};
      byte_r     <= 8'd0;
      prefetch_r <= 8'd0;
      nib_lo_r   <= 1'b0;
      first_r    <= 1'b1;
      rd_dly_r   <= 1'b0;
    end else begin
      rd_dly_r <= mem_rd_r;
      if (state_r == IDLE || state_nxt_s != state_r) begin
        cnt_r <= 8'd0;
      end else if (rise_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
      if (rise_s && state_r == CMD) begin
        cmd_r <= {cmd_r[5:0], sd_s[0]};
      end
      if (rise_s && state_r == ADDR) begin
        addr_r <= {addr_r[ADDR_BITS-5:0], sd_s};
      end else if (fall_s && state_r == DATA && nib_lo_r) begin
        addr_r <= addr_inc_s;
      end
      if (state_r != DATA) begin
        nib_lo_r <= 1'b0;
        first_r  <= 1'b1;
      end else if (fall_s) begin
        nib_lo_r <= ~nib_lo_r;
        if (!nib_lo_r) begin
          first_r <= 1'b0;
        end
      end
      // The ROM answers one clk after mem_rd: the DUMMY read fills byte_r, later ones prefetch
      if (rd_dly_r && state_r == DUMMY) begin
        byte_r <= mem_data;
      end else if (fall_s && state_r == DATA && !nib_lo_r && !first_r) begin
        byte_r <= prefetch_r;
      end
      if (rd_dly_r && state_r != DUMMY) begin
        prefetch_r <= mem_data;
      end
    end
  end

  assign spi_data_out = out_r;
  assign spi_data_oe  = oe_r;
  assign mem_addr     = mem_addr_r;
  assign mem_rd       = mem_rd_r;
  assign busy         = busy_r;
  assign cmd_error    = cmd_error_r;

endmodule
